// File: rtl/matmul_pkg.sv
// Shared constants and loader state encoding for the matrix-multiply front end.
package matmul_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int ROWS   = 2;
    localparam int COLS   = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } loader_state_e;
endpackage

// File: rtl/beat_counter.sv
// Mod-N beat counter with synchronous clear; wrap_o flags the enabled final count.
module beat_counter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = en_i && (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/matrix_stream_loader.sv
// Streams ROWS*COLS bytes into memory A, then B, and pulses load_done.
// Optional trailing-checksum beat enabled by defining LOADER_CHECKSUM_EN.
module matrix_stream_loader #(
    parameter int ROWS   = matmul_pkg::ROWS,
    parameter int COLS   = matmul_pkg::COLS,
    parameter int DATA_W = matmul_pkg::DATA_W,
    parameter int ADDR_W = matmul_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              write_A,
    output logic [ADDR_W-1:0] write_address_A,
    output logic [DATA_W-1:0] write_value_A,
    output logic              write_B,
    output logic [ADDR_W-1:0] write_address_B,
    output logic [DATA_W-1:0] write_value_B,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);
    import matmul_pkg::*;

    localparam int N     = ROWS * COLS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (N > 2**ADDR_W) begin : g_addr_check
        $error("matrix_stream_loader: ROWS*COLS exceeds the ADDR_W address space");
    end

    loader_state_e     state_q, state_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wr_a_q, wr_b_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wval_q;

    logic              accept, cnt_en, cnt_clr, cnt_wrap;
    logic [CNT_W-1:0]  idx;

    // s_ready is registered, so accept only ever sees a load state's beat.
    assign accept  = s_valid & s_ready_q;
    assign cnt_en  = accept & ((state_q == LOAD_A) || (state_q == LOAD_B));
    assign cnt_clr = (state_q == IDLE) & start;

    beat_counter #(.N(N), .W(CNT_W)) u_beat_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (idx),
        .wrap_o (cnt_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD_A;
            LOAD_A:  if (cnt_wrap) state_d = LOAD_B;
`ifdef LOADER_CHECKSUM_EN
            LOAD_B:  if (cnt_wrap) state_d = CHECK;
`else
            LOAD_B:  if (cnt_wrap) state_d = DONE;
`endif
            CHECK:   if (accept) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready/busy follow the upcoming state; load_done lags DONE so it trails the last write.
    always_comb begin
        s_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B) || (state_d == CHECK);
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_a_q    <= 1'b0;
            wr_b_q    <= 1'b0;
            waddr_q   <= '0;
            wval_q    <= '0;
        end else begin
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_a_q    <= cnt_en & (state_q == LOAD_A);
            wr_b_q    <= cnt_en & (state_q == LOAD_B);
            if (cnt_en) begin
                waddr_q <= ADDR_W'(idx);
                wval_q  <= s_data;
            end
        end
    end

    assign s_ready         = s_ready_q;
    assign busy            = busy_q;
    assign load_done       = done_q;
    assign write_A         = wr_a_q;
    assign write_B         = wr_b_q;
    assign write_address_A = waddr_q;
    assign write_address_B = waddr_q;
    assign write_value_A   = wval_q;
    assign write_value_B   = wval_q;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (cnt_clr) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (cnt_en)
                sum_q <= sum_q + 8'(s_data);
            if ((state_q == CHECK) && accept)
                err_q <= (8'(s_data) != sum_q);
        end
    end

    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader; models both memories from the write ports.
module tb_matrix_stream_loader;
    logic       clk = 1'b0;
    logic       rst, start, s_valid;
    logic [7:0] s_data;
    logic       s_ready, write_A, write_B, busy, load_done, load_err;
    logic [5:0] write_address_A, write_address_B;
    logic [7:0] write_value_A, write_value_B;

    matrix_stream_loader dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .write_A         (write_A),
        .write_address_A (write_address_A),
        .write_value_A   (write_value_A),
        .write_B         (write_B),
        .write_address_B (write_address_B),
        .write_value_B   (write_value_B),
        .busy            (busy),
        .load_done       (load_done),
        .load_err        (load_err)
    );

    always #5 clk = ~clk;

`ifdef LOADER_CHECKSUM_EN
    localparam int CHK_EXTRA = 1;
`else
    localparam int CHK_EXTRA = 0;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] memA [64];
    logic [7:0] memB [64];
    int a_addr [$];
    int b_addr [$];
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0, firstw_cyc = -1, lastb_cyc = 0, overlap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (write_A) begin
                memA[write_address_A] = write_value_A;
                a_addr.push_back(int'(write_address_A));
                if (firstw_cyc < 0) firstw_cyc = cyc;
            end
            if (write_B) begin
                memB[write_address_B] = write_value_B;
                b_addr.push_back(int'(write_address_B));
                lastb_cyc = cyc;
            end
            if (write_A && write_B) overlap++;
            if (load_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_log;
        for (int i = 0; i < 64; i++) begin
            memA[i] = 8'hEE;
            memB[i] = 8'hEE;
        end
        a_addr.delete();
        b_addr.delete();
        firstw_cyc = -1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic send_beat(input logic [7:0] d, input bit with_start);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        start   = with_start;
        n = 0;
        while (s_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL beat_accept_timeout: s_ready=%b want 1", s_ready);
        end else begin
            @(negedge clk);
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic send_load(input logic [7:0] d [8], input int bubble_gap,
                             input bit start_on_last, input logic [7:0] chk_bias);
        logic [7:0] sum;
        sum = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (bubble_gap > 0 && (i == 1 || i == 5)) repeat (bubble_gap) @(negedge clk);
            sum = sum + d[i];
            send_beat(d[i], start_on_last && (i == 7) && (CHK_EXTRA == 0));
        end
`ifdef LOADER_CHECKSUM_EN
        send_beat(sum + chk_bias, start_on_last);
`else
        if (chk_bias != 8'd0) sum = 8'd0;
`endif
    endtask

    task automatic test_reset;
        int viol;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        #3;
        total++;
        if ({s_ready, write_A, write_B, busy, load_done, load_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {s_ready, write_A, write_B, busy, load_done, load_err});
        end
        total++;
        if ({write_address_A, write_value_A, write_address_B, write_value_B} !== 28'h0) begin
            bad++;
            $display("FAIL reset_addr_data: got %h want 0",
                     {write_address_A, write_value_A, write_address_B, write_value_B});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
        s_valid = 1'b1;
        s_data  = 8'h55;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({s_ready, write_A, write_B, busy, load_done} !== 5'b0) viol++;
        end
        s_valid = 1'b0;
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL idle_quiet: got %0d active cycles want 0", viol);
        end
        total++;
        if (a_addr.size() + b_addr.size() !== 0) begin
            bad++;
            $display("FAIL idle_no_writes: got %0d writes want 0", a_addr.size() + b_addr.size());
        end
    endtask

    task automatic test_back_to_back;
        int base;
        clear_log();
        base = done_cnt;
        pulse_start();
        send_load('{8'd1, 8'd3, 8'd5, 8'd7, 8'd0, 8'd2, 8'd4, 8'd6}, 0, 1'b0, 8'd0);
        settle(6);
        total++;
        if ({memA[0], memA[1], memA[2], memA[3]} !== 32'h01030507) begin
            bad++;
            $display("FAIL b2b_memA: got %h want 01030507", {memA[0], memA[1], memA[2], memA[3]});
        end
        total++;
        if ({memB[0], memB[1], memB[2], memB[3]} !== 32'h00020406) begin
            bad++;
            $display("FAIL b2b_memB: got %h want 00020406", {memB[0], memB[1], memB[2], memB[3]});
        end
        total++;
        if (done_cnt - base !== 1) begin
            bad++;
            $display("FAIL b2b_done_count: got %0d want 1", done_cnt - base);
        end
        total++;
        if (done_cyc - lastb_cyc !== 1 + CHK_EXTRA) begin
            bad++;
            $display("FAIL b2b_done_latency: got %0d want %0d", done_cyc - lastb_cyc, 1 + CHK_EXTRA);
        end
        total++;
        if (done_cyc - firstw_cyc !== 8 + CHK_EXTRA) begin
            bad++;
            $display("FAIL b2b_span: got %0d want %0d", done_cyc - firstw_cyc, 8 + CHK_EXTRA);
        end
        total++;
        if ({busy, s_ready, overlap != 0} !== 3'b000) begin
            bad++;
            $display("FAIL b2b_after: got busy=%b ready=%b overlap=%0d want 0 0 0", busy, s_ready, overlap);
        end
    endtask

    task automatic test_bubbles;
        bit ok;
        clear_log();
        pulse_start();
        send_load('{8'd1, 8'd3, 8'd5, 8'd7, 8'd0, 8'd2, 8'd4, 8'd6}, 2, 1'b0, 8'd0);
        settle(6);
        total++;
        if ({memA[0], memA[1], memA[2], memA[3], memB[0], memB[1], memB[2], memB[3]}
                !== 64'h0103050700020406) begin
            bad++;
            $display("FAIL bubble_mem: got %h want 0103050700020406",
                     {memA[0], memA[1], memA[2], memA[3], memB[0], memB[1], memB[2], memB[3]});
        end
        ok = (a_addr.size() == 4) && (b_addr.size() == 4);
        for (int i = 0; i < 4; i++)
            if (ok && (a_addr[i] != i || b_addr[i] != i)) ok = 1'b0;
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL bubble_addr_seq: got sizes %0d/%0d or out of order, want 0..3 each",
                     a_addr.size(), b_addr.size());
        end
        total++;
        if (done_cyc - firstw_cyc !== 12 + CHK_EXTRA) begin
            bad++;
            $display("FAIL bubble_span: got %0d want %0d", done_cyc - firstw_cyc, 12 + CHK_EXTRA);
        end
    endtask

    task automatic test_reset_abort;
        int base;
        clear_log();
        base = done_cnt;
        pulse_start();
        send_beat(8'd1, 1'b0);
        send_beat(8'd2, 1'b0);
        send_beat(8'd3, 1'b0);
        #2 rst = 1'b1;
        #4;
        total++;
        if ({busy, s_ready, write_A} !== 3'b000) begin
            bad++;
            $display("FAIL abort_outputs: got %b want 000", {busy, s_ready, write_A});
        end
        @(negedge clk);
        rst = 1'b0;
        settle(5);
        total++;
        if (done_cnt !== base) begin
            bad++;
            $display("FAIL abort_no_done: got %0d want %0d", done_cnt, base);
        end
        pulse_start();
        send_load('{8'd9, 8'd9, 8'd9, 8'd9, 8'd8, 8'd8, 8'd8, 8'd8}, 0, 1'b0, 8'd0);
        settle(6);
        total++;
        if ({memA[0], memA[1], memA[2], memA[3], memB[0], memB[1], memB[2], memB[3]}
                !== 64'h0909090908080808) begin
            bad++;
            $display("FAIL abort_reload_mem: got %h want 0909090908080808",
                     {memA[0], memA[1], memA[2], memA[3], memB[0], memB[1], memB[2], memB[3]});
        end
        total++;
        if (done_cnt !== base + 1) begin
            bad++;
            $display("FAIL abort_reload_done: got %0d want %0d", done_cnt, base + 1);
        end
    endtask

    task automatic test_start_while_busy;
        int base;
        clear_log();
        base = done_cnt;
        pulse_start();
        for (int i = 0; i < 4; i++) send_beat(8'(10 + i), 1'b0);
        send_beat(8'd20, 1'b0);
        send_beat(8'd21, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_beat(8'd22, 1'b0);
        send_beat(8'd23, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_beat(8'd132, 1'b0);
`endif
        settle(6);
        total++;
        if (done_cnt - base !== 1) begin
            bad++;
            $display("FAIL busy_start_done_count: got %0d want 1", done_cnt - base);
        end
        total++;
        if ({memA[0], memA[1], memA[2], memA[3], memB[0], memB[1], memB[2], memB[3]}
                !== 64'h0A0B0C0D14151617) begin
            bad++;
            $display("FAIL busy_start_mem: got %h want 0a0b0c0d14151617",
                     {memA[0], memA[1], memA[2], memA[3], memB[0], memB[1], memB[2], memB[3]});
        end
        pulse_start();
        total++;
        if ({busy, s_ready} !== 2'b11) begin
            bad++;
            $display("FAIL next_start_accepted: got %b want 11", {busy, s_ready});
        end
        send_load('{8'd30, 8'd31, 8'd32, 8'd33, 8'd34, 8'd35, 8'd36, 8'd37}, 0, 1'b1, 8'd0);
        settle(6);
        total++;
        if (done_cnt - base !== 2) begin
            bad++;
            $display("FAIL last_beat_start_done: got %0d want 2", done_cnt - base);
        end
        total++;
        if ({busy, s_ready} !== 2'b00) begin
            bad++;
            $display("FAIL last_beat_start_dropped: got %b want 00", {busy, s_ready});
        end
        total++;
        if ({memB[0], memB[3]} !== 16'h2225) begin
            bad++;
            $display("FAIL last_beat_start_mem: got %h want 2225", {memB[0], memB[3]});
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum;
        int base;
        clear_log();
        base = done_cnt;
        pulse_start();
        send_load('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 0, 1'b0, 8'd0);
        settle(6);
        total++;
        if ({load_err, b_addr.size() == 4} !== 2'b01) begin
            bad++;
            $display("FAIL chk_good: got err=%b bwrites=%0d want 0 4", load_err, b_addr.size());
        end
        pulse_start();
        send_load('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 0, 1'b0, 8'hFF);
        settle(6);
        total++;
        if (load_err !== 1'b1) begin
            bad++;
            $display("FAIL chk_bad_err: got %b want 1", load_err);
        end
        total++;
        if (done_cnt - base !== 2) begin
            bad++;
            $display("FAIL chk_bad_done: got %0d want 2", done_cnt - base);
        end
        pulse_start();
        #1;
        total++;
        if (load_err !== 1'b0) begin
            bad++;
            $display("FAIL chk_clear_on_start: got %b want 0", load_err);
        end
        send_load('{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 1'b0, 8'd0);
        settle(6);
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_reset_abort();
        test_start_while_busy();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`else
        total++;
        if (load_err !== 1'b0) begin
            bad++;
            $display("FAIL err_tied_low: got %b want 0", load_err);
        end
`endif
        total++;
        if (overlap !== 0) begin
            bad++;
            $display("FAIL ab_overlap: got %0d want 0", overlap);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
